// File: rtl/soc_miner_pkg.sv
// Shared definitions for the miner-side AXI3 memory arbiters.
package soc_miner_pkg;

    localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
    localparam logic [3:0] AXI_CACHE_BUFMOD = 4'b0011;
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    // Read arbiter FSM: IDLE picks a requester, ISSUE holds the AR until accepted.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } rd_arb_state_t;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // AXI size code for a data bus of the given width in bits.
    function automatic logic [2:0] axi_size(input int width);
        return 3'(clog2(width / 8));
    endfunction

endpackage

// File: rtl/soc_miner_rr_arbiter.sv
// Round-robin pick: the first set request strictly after ptr, wrapping.
module soc_miner_rr_arbiter
    import soc_miner_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          any
);

    // Scan offsets 1..N from the pointer; the pointer itself comes last.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!any && req[(int'(ptr) + k) % N]) begin
                grant[(int'(ptr) + k) % N] = 1'b1;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/soc_miner_rd_arbiter.sv
// Shares one AXI3 read channel between NUM_REQ work fetchers.
// Handshake rule on every channel: a transfer happens in the cycle where
// valid and ready are both high; valid, once raised, holds its payload
// stable until that cycle. One burst outstanding per requester; R beats
// are routed back by RID, which carries the requester index.
module soc_miner_rd_arbiter
    import soc_miner_pkg::*;
#(
    parameter int NUM_REQ              = 4,
    parameter int MEMORY_DATA_WIDTH    = 64,
    parameter int MEMORY_ADDR_WIDTH    = 32,
    parameter int MEMORY_BUS_LEN_WIDTH = 4,
    parameter int MEMORY_ID_WIDTH      = 6
) (
    input  logic                                    Clk,
    input  logic                                    Rst,
    input  logic [NUM_REQ-1:0]                      req_arvalid,
    output logic [NUM_REQ-1:0]                      req_arready,
    input  logic [NUM_REQ*MEMORY_ADDR_WIDTH-1:0]    req_araddr,
    input  logic [NUM_REQ*MEMORY_BUS_LEN_WIDTH-1:0] req_arlen,
    output logic [NUM_REQ-1:0]                      req_rvalid,
    input  logic [NUM_REQ-1:0]                      req_rready,
    output logic [MEMORY_DATA_WIDTH-1:0]            req_rdata,
    output logic                                    req_rlast,
    output logic [1:0]                              req_rresp,
    output logic                                    m_memory_arvalid,
    input  logic                                    m_memory_arready,
    output logic [MEMORY_ADDR_WIDTH-1:0]            m_memory_araddr,
    output logic [MEMORY_BUS_LEN_WIDTH-1:0]         m_memory_arlen,
    output logic [MEMORY_ID_WIDTH-1:0]              m_memory_arid,
    output logic [2:0]                              m_memory_arsize,
    output logic [1:0]                              m_memory_arburst,
    output logic [1:0]                              m_memory_arlock,
    output logic [3:0]                              m_memory_arcache,
    output logic [2:0]                              m_memory_arprot,
    output logic [3:0]                              m_memory_arqos,
    input  logic                                    m_memory_rvalid,
    output logic                                    m_memory_rready,
    input  logic [MEMORY_DATA_WIDTH-1:0]            m_memory_rdata,
    input  logic                                    m_memory_rlast,
    input  logic [1:0]                              m_memory_rresp,
    input  logic [MEMORY_ID_WIDTH-1:0]              m_memory_rid,
    output logic [NUM_REQ-1:0]                      pending,
    output logic                                    err_unexp,
    output rd_arb_state_t                           fsm_state
);

    localparam int IDXW = clog2(NUM_REQ);

    rd_arb_state_t      state, state_next;
    logic [IDXW-1:0]    ptr, gnt_idx, ar_idx, r_idx;
    logic [NUM_REQ-1:0] eligible, grant, pend_set, pend_clr;
    logic               grant_any, r_ok;

    assign fsm_state = state;
    assign eligible  = req_arvalid & ~pending;

    soc_miner_rr_arbiter #(.N(NUM_REQ), .PW(IDXW)) u_rr (
        .req   (eligible),
        .ptr   (ptr),
        .grant (grant),
        .any   (grant_any)
    );

    // One-hot grant to requester index.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) gnt_idx = IDXW'(i);
        end
    end

    // Next state and the combinational requester accept (IDLE only).
    always_comb begin
        state_next  = state;
        req_arready = '0;
        case (state)
            ST_IDLE: begin
                if (grant_any) begin
                    req_arready = grant;
                    state_next  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (m_memory_arready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, round-robin pointer and the AR register captured at grant.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state           <= ST_IDLE;
            ptr             <= IDXW'(NUM_REQ - 1);
            ar_idx          <= '0;
            m_memory_araddr <= '0;
            m_memory_arlen  <= '0;
            m_memory_arid   <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && grant_any) begin
                ar_idx          <= gnt_idx;
                m_memory_araddr <= req_araddr[int'(gnt_idx)*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
                m_memory_arlen  <= req_arlen[int'(gnt_idx)*MEMORY_BUS_LEN_WIDTH +: MEMORY_BUS_LEN_WIDTH];
                m_memory_arid   <= MEMORY_ID_WIDTH'(gnt_idx);
            end
            if (state == ST_ISSUE && m_memory_arready) ptr <= ar_idx;
        end
    end

    assign m_memory_arvalid = (state == ST_ISSUE);
    assign m_memory_arsize  = axi_size(MEMORY_DATA_WIDTH);
    assign m_memory_arburst = AXI_BURST_INCR;
    assign m_memory_arlock  = 2'b00;
    assign m_memory_arcache = AXI_CACHE_BUFMOD;
    assign m_memory_arprot  = AXI_PROT_DEFAULT;
    assign m_memory_arqos   = 4'b0000;

    // RID router: beats for unknown or idle IDs are drained and flagged.
    always_comb begin
        r_idx           = m_memory_rid[IDXW-1:0];
        r_ok            = (int'(m_memory_rid) < NUM_REQ) && pending[r_idx];
        req_rvalid      = '0;
        m_memory_rready = 1'b1;
        pend_clr        = '0;
        if (r_ok) begin
            req_rvalid[r_idx] = m_memory_rvalid;
            m_memory_rready   = req_rready[r_idx];
            if (m_memory_rvalid && req_rready[r_idx] && m_memory_rlast) pend_clr[r_idx] = 1'b1;
        end
    end

    // Burst becomes outstanding when the AR is accepted downstream.
    always_comb begin
        pend_set = '0;
        if (state == ST_ISSUE && m_memory_arready) pend_set[ar_idx] = 1'b1;
    end

    assign req_rdata = m_memory_rdata;
    assign req_rlast = m_memory_rlast;
    assign req_rresp = m_memory_rresp;

    // Outstanding-burst flags and the sticky unexpected-beat flag.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            pending   <= '0;
            err_unexp <= 1'b0;
        end else begin
            pending <= (pending & ~pend_clr) | pend_set;
            if (m_memory_rvalid && !r_ok) err_unexp <= 1'b1;
        end
    end

endmodule

// File: tb/tb_soc_miner_rd_arbiter.sv
// Randomized bench for soc_miner_rd_arbiter against a queue-based model.
module tb_soc_miner_rd_arbiter;
    import soc_miner_pkg::*;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int AW = 32;
    localparam int LW = 4;
    localparam int IW = 6;
    localparam int W  = IW + LW + AW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req_arvalid, req_arready, req_rvalid, req_rready, pending;
    logic [N*AW-1:0] req_araddr;
    logic [N*LW-1:0] req_arlen;
    logic [DW-1:0]   req_rdata, m_rdata;
    logic            req_rlast, m_rlast, m_arvalid, m_arready, m_rvalid, m_rready, err_unexp;
    logic [1:0]      req_rresp, m_rresp, m_arburst, m_arlock;
    logic [AW-1:0]   m_araddr;
    logic [LW-1:0]   m_arlen;
    logic [IW-1:0]   m_arid, m_rid;
    logic [2:0]      m_arsize, m_arprot;
    logic [3:0]      m_arcache, m_arqos;
    rd_arb_state_t   fsm_state;

    soc_miner_rd_arbiter #(
        .NUM_REQ(N), .MEMORY_DATA_WIDTH(DW), .MEMORY_ADDR_WIDTH(AW),
        .MEMORY_BUS_LEN_WIDTH(LW), .MEMORY_ID_WIDTH(IW)
    ) dut (
        .Clk(clk), .Rst(rst),
        .req_arvalid(req_arvalid), .req_arready(req_arready),
        .req_araddr(req_araddr), .req_arlen(req_arlen),
        .req_rvalid(req_rvalid), .req_rready(req_rready),
        .req_rdata(req_rdata), .req_rlast(req_rlast), .req_rresp(req_rresp),
        .m_memory_arvalid(m_arvalid), .m_memory_arready(m_arready),
        .m_memory_araddr(m_araddr), .m_memory_arlen(m_arlen), .m_memory_arid(m_arid),
        .m_memory_arsize(m_arsize), .m_memory_arburst(m_arburst), .m_memory_arlock(m_arlock),
        .m_memory_arcache(m_arcache), .m_memory_arprot(m_arprot), .m_memory_arqos(m_arqos),
        .m_memory_rvalid(m_rvalid), .m_memory_rready(m_rready), .m_memory_rdata(m_rdata),
        .m_memory_rlast(m_rlast), .m_memory_rresp(m_rresp), .m_memory_rid(m_rid),
        .pending(pending), .err_unexp(err_unexp), .fsm_state(fsm_state)
    );

    // ---------------- reference model state ----------------
    int n_checks = 0;
    int n_errors = 0;

    bit            rq_valid[N];
    logic [AW-1:0] rq_addr[N];
    logic [LW-1:0] rq_len[N];
    bit            pend[N];
    int            ptr;
    bit            ar_busy;
    int            ar_g;
    bit            exp_err;
    logic [W-1:0]  exp_q[$];
    int            mq_id[$];
    int            mq_len[$];
    bit            r_hold;
    int            r_beat;
    int            cyc;
    int            dut_gnt[$];
    int            dut_gcyc[$];

    int p_req, p_arready, p_rvalid, p_rready, max_len;
    bit bogus_en;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit model_busy();
        bit b;
        b = ar_busy || r_hold || (mq_id.size() > 0);
        for (int i = 0; i < N; i++) b = b || rq_valid[i];
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            rq_valid[i] = 1'b0;
            pend[i]     = 1'b0;
        end
        ptr     = N - 1;
        ar_busy = 1'b0;
        ar_g    = 0;
        exp_err = 1'b0;
        r_hold  = 1'b0;
        r_beat  = 0;
        exp_q.delete();
        mq_id.delete();
        mq_len.delete();
        dut_gnt.delete();
        dut_gcyc.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_ar_pins();
        for (int i = 0; i < N; i++) begin
            req_arvalid[i]          = rq_valid[i];
            req_araddr[i*AW +: AW]  = rq_addr[i];
            req_arlen[i*LW +: LW]   = rq_len[i];
        end
    endtask

    task automatic raise(input int i, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        rq_valid[i] = 1'b1;
        rq_addr[i]  = addr;
        rq_len[i]   = len;
        drive_ar_pins();
    endtask

    task automatic drive_next();
        for (int i = 0; i < N; i++) begin
            if (!rq_valid[i] && $urandom_range(99) < p_req) begin
                rq_valid[i] = 1'b1;
                rq_addr[i]  = $urandom;
                rq_len[i]   = LW'($urandom_range(max_len));
            end
        end
        drive_ar_pins();
        m_arready = ($urandom_range(99) < p_arready);
        for (int i = 0; i < N; i++) req_rready[i] = ($urandom_range(99) < p_rready);
        if (!bogus_en) begin
            if (!r_hold && mq_id.size() > 0 && $urandom_range(99) < p_rvalid) begin
                r_hold  = 1'b1;
                m_rid   = IW'(mq_id[0]);
                m_rlast = (r_beat == mq_len[0]);
                m_rdata = {$urandom, $urandom};
                m_rresp = 2'($urandom_range(3));
            end
            m_rvalid = r_hold;
        end
    endtask

    // Compare this cycle's DUT outputs with the model, then advance the
    // model by what the coming rising edge will do.
    task automatic check_cycle();
        logic [N-1:0] exp_ard, exp_rv, exp_pv;
        logic         exp_rr;
        int           g, rid_i;
        bit           route_ok;

        g = -1;
        if (!ar_busy) begin
            for (int k = 1; k <= N; k++) begin
                if (g < 0 && rq_valid[(ptr + k) % N] && !pend[(ptr + k) % N]) g = (ptr + k) % N;
            end
        end
        exp_ard = '0;
        if (g >= 0) exp_ard[g] = 1'b1;
        check("req_arready", 64'(req_arready), 64'(exp_ard));
        check("m_arvalid", 64'(m_arvalid), 64'(ar_busy));
        if (ar_busy && exp_q.size() > 0)
            check("ar_stable", 64'({m_arid, m_arlen, m_araddr}), 64'(exp_q[0]));

        rid_i    = int'(m_rid);
        route_ok = (rid_i < N) && pend[rid_i % N];
        exp_rv   = '0;
        exp_rr   = 1'b1;
        if (route_ok) begin
            exp_rv[rid_i] = m_rvalid;
            exp_rr        = req_rready[rid_i];
        end
        check("req_rvalid", 64'(req_rvalid), 64'(exp_rv));
        check("m_rready", 64'(m_rready), 64'(exp_rr));
        if (m_rvalid && route_ok) check("rdata", req_rdata, m_rdata);

        exp_pv = '0;
        for (int i = 0; i < N; i++) exp_pv[i] = pend[i];
        check("pending", 64'(pending), 64'(exp_pv));
        check("err_unexp", 64'(err_unexp), 64'(exp_err));

        if (req_arready != '0) begin
            for (int i = 0; i < N; i++) if (req_arready[i]) dut_gnt.push_back(i);
            dut_gcyc.push_back(cyc);
        end

        // R channel consequences
        if (m_rvalid && !route_ok) exp_err = 1'b1;
        if (r_hold && m_rvalid && exp_rr) begin
            r_hold = 1'b0;
            if (m_rlast) begin
                pend[rid_i % N] = 1'b0;
                void'(mq_id.pop_front());
                void'(mq_len.pop_front());
                r_beat = 0;
            end else begin
                r_beat++;
            end
        end

        // AR channel consequences
        if (g >= 0) begin
            ar_busy     = 1'b1;
            ar_g        = g;
            exp_q.push_back({IW'(g), rq_len[g], rq_addr[g]});
            rq_valid[g] = 1'b0;
        end else if (ar_busy && m_arready) begin
            check("ar_handshake", 64'({m_arid, m_arlen, m_araddr}), 64'(exp_q.pop_front()));
            pend[ar_g] = 1'b1;
            ptr        = ar_g;
            ar_busy    = 1'b0;
            mq_id.push_back(ar_g);
            mq_len.push_back(int'(m_arlen));
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        drive_next();
    endtask

    task automatic drain();
        int budget;
        budget    = 3000;
        p_req     = 0;
        p_arready = 100;
        p_rvalid  = 100;
        p_rready  = 100;
        while (model_busy() && budget > 0) begin
            step();
            budget--;
        end
        check("drain_done", 64'(model_busy()), 64'(0));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int order[5];
        int n0;
        order = '{0, 1, 2, 3, 0};
        cyc = 0;
        bogus_en = 1'b0;
        req_arvalid = '0; req_araddr = '0; req_arlen = '0; req_rready = '0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rlast = 1'b0;
        m_rresp = '0; m_rid = '0;
        for (int i = 0; i < N; i++) begin
            rq_addr[i] = '0;
            rq_len[i]  = '0;
        end
        model_reset();

        // Reset values and constant AR attributes
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_arvalid", 64'(m_arvalid), 64'(0));
        check("rst_ar_fields", 64'({m_arid, m_arlen, m_araddr}), 64'(0));
        check("rst_pending", 64'(pending), 64'(0));
        check("rst_err", 64'(err_unexp), 64'(0));
        check("rst_arready", 64'(req_arready), 64'(0));
        check("ar_const", 64'({m_arsize, m_arburst, m_arlock, m_arcache, m_arprot, m_arqos}),
              64'({3'b011, 2'b01, 2'b00, 4'b0011, 3'b000, 4'b0000}));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // All four request continuously, instant arready, single-beat bursts
        p_req = 100; p_arready = 100; p_rvalid = 100; p_rready = 100; max_len = 0;
        drive_next();
        repeat (12) step();
        for (int i = 0; i < 5; i++) begin
            check("t2_order", (i < dut_gnt.size()) ? 64'(dut_gnt[i]) : 64'hffff, 64'(order[i]));
            if (i > 0)
                check("t2_spacing", (i < dut_gcyc.size()) ? 64'(dut_gcyc[i] - dut_gcyc[i-1]) : 64'hffff, 64'(2));
        end
        drain();

        // Single request: req0, addr 0x1000_0000, len 3
        dut_gnt.delete();
        raise(0, 32'h1000_0000, 4'd3);
        repeat (10) step();
        check("t1_granted", (dut_gnt.size() > 0) ? 64'(dut_gnt[0]) : 64'hffff, 64'(0));
        check("t1_pending_clear", 64'(pending), 64'(0));

        // arready held low: one grant, then AR frozen
        n0 = dut_gnt.size();
        p_arready = 0; p_rvalid = 100; p_rready = 100;
        for (int i = 0; i < N; i++) raise(i, 32'h2000_0000 + 32'(i * 64), LW'(i));
        repeat (12) step();
        check("t3_one_grant", 64'(dut_gnt.size() - n0), 64'(1));

        // Random traffic
        p_req = 30; p_arready = 50; p_rvalid = 60; p_rready = 70; max_len = 7;
        repeat (3000) step();
        drain();

        // Unexpected beats: out-of-range RID, then an idle requester's RID
        bogus_en = 1'b1;
        m_rvalid = 1'b1; m_rid = 6'd5; m_rlast = 1'b1; m_rdata = {$urandom, $urandom};
        step();
        m_rid = 6'd2;
        step();
        check("t5_err_set", 64'(err_unexp), 64'(1));
        m_rvalid = 1'b0;
        repeat (3) step();
        bogus_en = 1'b0;

        // Async reset while an AR waits in ISSUE with pending = 0101
        p_req = 0; p_arready = 100; p_rvalid = 0; p_rready = 100;
        raise(0, 32'h3000_0000, 4'd1);
        raise(2, 32'h3000_1000, 4'd1);
        repeat (6) step();
        check("t6_pending_setup", 64'(pending), 64'(4'b0101));
        p_arready = 0;
        raise(1, 32'h3000_2000, 4'd0);
        repeat (2) step();
        check("t6_in_issue", 64'(m_arvalid), 64'(1));
        for (int i = 0; i < N; i++) rq_valid[i] = 1'b0;
        drive_ar_pins();
        #2;
        rst = 1'b1;
        #1;
        check("t6_arvalid_async", 64'(m_arvalid), 64'(0));
        check("t6_pending_async", 64'(pending), 64'(0));
        check("t6_err_async", 64'(err_unexp), 64'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        p_arready = 100; p_rvalid = 100; p_rready = 100;
        for (int i = 0; i < N; i++) raise(i, 32'h4000_0000 + 32'(i * 256), 4'd0);
        repeat (2) step();
        check("t6_first_grant", (dut_gnt.size() > 0) ? 64'(dut_gnt[0]) : 64'hffff, 64'(0));
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
